madd_err_sweep_ctrl: RTL

- Sequencer for one combinational approximate multiply-add instance (y ≈ a*b + c; 6-bit a, b, c; 12-bit y).
- Sweeps the full operand space exhaustively, drives the instance's operand inputs and samples its result.
- Compares each result against an internally computed exact a*b + c and accumulates error statistics.
- Sits beside each approximate madd variant in the error-evaluation harness; one controller per candidate circuit.

---
 rtl/madd_err_sweep_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/madd_err_sweep_ctrl.sv
// madd_err_sweep_ctrl: exhaustive operand sweep and error-statistics
// accumulator for one combinational approximate multiply-add (y ~ a*b + c).
// Optional build macro MADD_ERR_WCE_CAPTURE_EN adds wce_a/wce_b/wce_c, the
// operands of the first vector that produced the worst error.
//
// Handshake: start is a level sampled only in IDLE; abort is a level sampled
// in RUN/DRAIN; done is a one-cycle pulse; busy covers RUN and DRAIN.
module madd_err_sweep_ctrl #(
   parameter int A_W   = 6,
   parameter int B_W   = 6,
   parameter int C_W   = 6,
   parameter int Y_W   = 12,
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [A_W-1:0]   op_a,
   output logic [B_W-1:0]   op_b,
   output logic [C_W-1:0]   op_c,
   input  logic [Y_W-1:0]   app_y,
`ifdef MADD_ERR_WCE_CAPTURE_EN
   output logic [A_W-1:0]   wce_a,
   output logic [B_W-1:0]   wce_b,
   output logic [C_W-1:0]   wce_c,
`endif
   output logic [ACC_W-1:0] err_cnt,
   output logic [ACC_W-1:0] err_sum,
   output logic [Y_W-1:0]   err_max
);

   localparam int V_W = A_W + B_W + C_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]     state;
   logic           drain_cnt;
   // The vector counter is itself the registered operand bus; it holds the
   // final vector through DRAIN and is reloaded with 0 on the next start.
   logic [V_W-1:0] vc;

   logic           v1;
   logic [Y_W-1:0] y1;
   logic [Y_W-1:0] e1;
`ifdef MADD_ERR_WCE_CAPTURE_EN
   logic [A_W-1:0] a1;
   logic [B_W-1:0] b1;
   logic [C_W-1:0] c1;
`endif

   logic [Y_W-1:0]   exact_y;
   logic [Y_W-1:0]   d;
   logic [ACC_W:0]   sum_ext;
   logic [ACC_W-1:0] sum_next;
   logic [ACC_W-1:0] cnt_next;
   logic             start_ok;

   assign {op_c, op_b, op_a} = vc;
   assign busy     = (state == S_RUN) || (state == S_DRAIN);
   assign done     = (state == S_DONE);
   assign start_ok = (state == S_IDLE) && start;

   // Exact reference result and saturating statistic updates
   always_comb begin
      exact_y  = Y_W'(op_a) * Y_W'(op_b) + Y_W'(op_c);
      d        = (y1 >= e1) ? (y1 - e1) : (e1 - y1);
      sum_ext  = {1'b0, err_sum} + (ACC_W + 1)'(d);
      sum_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      cnt_next = (&err_cnt) ? err_cnt : err_cnt + ACC_W'(1);
   end

   // Sequencer FSM and vector counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         drain_cnt <= 1'b0;
         vc        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  vc    <= '0;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (&vc) begin
                  state     <= S_DRAIN;
                  drain_cnt <= 1'b0;
               end else begin
                  vc <= vc + V_W'(1);
               end
            end
            S_DRAIN: begin
               if (abort)          state <= S_IDLE;
               else if (drain_cnt) state <= S_DONE;
               else                drain_cnt <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // S1: capture the approximate and exact results of the presented vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         y1 <= '0;
         e1 <= '0;
`ifdef MADD_ERR_WCE_CAPTURE_EN
         a1 <= '0;
         b1 <= '0;
         c1 <= '0;
`endif
      end else begin
         v1 <= (state == S_RUN) && !abort;
         if (state == S_RUN) begin
            y1 <= app_y;
            e1 <= exact_y;
`ifdef MADD_ERR_WCE_CAPTURE_EN
            a1 <= op_a;
            b1 <= op_b;
            c1 <= op_c;
`endif
         end
      end
   end

   // S2: accumulate error statistics; start clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
         err_sum <= '0;
         err_max <= '0;
      end else if (start_ok) begin
         err_cnt <= '0;
         err_sum <= '0;
         err_max <= '0;
      end else if (v1) begin
         if (d != '0)     err_cnt <= cnt_next;
         err_sum <= sum_next;
         if (d > err_max) err_max <= d;
      end
   end

`ifdef MADD_ERR_WCE_CAPTURE_EN
   // Worst-case operands: strict comparison keeps the earliest on ties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wce_a <= '0;
         wce_b <= '0;
         wce_c <= '0;
      end else if (start_ok) begin
         wce_a <= '0;
         wce_b <= '0;
         wce_c <= '0;
      end else if (v1 && (d > err_max)) begin
         wce_a <= a1;
         wce_b <= b1;
         wce_c <= c1;
      end
   end
`endif

endmodule
